// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX register bank.
//   DLX_DATA_W / DLX_ADDR_W : default register width and address width
//   REG_ZERO                : address of the hardwired-zero register
//   dbg_state_t             : debug read FSM state encoding
package dlx_pkg;

    localparam int DLX_DATA_W = 32;
    localparam int DLX_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } dbg_state_t;

endpackage

// File: rtl/reg_read_port.sv
// Combinational register read port.
// Masks reads of R0 to zero and, when BYPASS_EN is set, forwards the
// write-back data if the register being read is written in this same cycle.
// Ports:
//   rd_addr  : register address being read
//   wr_en    : write enable of the write-back stage
//   wr_addr  : register being written this cycle
//   bus_w    : data being written this cycle
//   reg_data : current stored contents of reg[rd_addr]
//   data     : resolved read value
module reg_read_port
    import dlx_pkg::*;
#(
    parameter int DATA_W    = DLX_DATA_W,
    parameter int ADDR_W    = DLX_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] bus_w,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = reg_data;
        if (rd_addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end else if (BYPASS_EN && wr_en && (wr_addr == rd_addr)) begin
            // Write-through: decode sees the value WB is committing now.
            data = bus_w;
        end
    end

endmodule

// File: rtl/reg_bank_wb.sv
// 2**ADDR_W x DATA_W register bank fed by the write-back stage.
// Two combinational operand read ports (with optional write-through bypass),
// a registered debug read port driven by a small FSM, and a saturating
// counter of committed writes to R1..R(N-1).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   wr_en, wr_addr, bus_w: write-back port
//   rd_addr_a, bus_a     : rs operand read port
//   rd_addr_b, bus_b     : rt operand read port
//   dbg_req, dbg_addr    : debug read request (single-cycle pulse)
//   dbg_data, dbg_valid  : registered debug read result and its strobe
//   wr_count             : saturating count of committed writes
module reg_bank_wb
    import dlx_pkg::*;
#(
    parameter int DATA_W    = DLX_DATA_W,
    parameter int ADDR_W    = DLX_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] bus_w,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_valid,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic              wr_commit;

    // R0 is never selected, so it keeps its reset value of zero.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_zero
                assign wr_sel[gi] = 1'b0;
            end else begin : g_reg
                assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    assign wr_commit = |wr_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= bus_w;
                end
            end
        end
    end

    // Write counter, saturating at all-ones.
    logic [15:0] wr_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_reg <= '0;
        end else if (wr_commit && (wr_count_reg != 16'hFFFF)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    assign wr_count = wr_count_reg;

    // Operand read ports.
    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BYPASS_EN(BYPASS_EN)
    ) u_port_a (
        .rd_addr (rd_addr_a),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .bus_w   (bus_w),
        .reg_data(regs[rd_addr_a]),
        .data    (bus_a)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BYPASS_EN(BYPASS_EN)
    ) u_port_b (
        .rd_addr (rd_addr_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .bus_w   (bus_w),
        .reg_data(regs[rd_addr_b]),
        .data    (bus_b)
    );

    // Debug read FSM. The address is latched on the request edge; the value
    // is sampled at the end of the CAPTURE cycle so a write landing in that
    // same cycle is seen through the bypass.
    dbg_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] dbg_addr_reg, dbg_addr_next;
    logic [DATA_W-1:0] dbg_data_reg, dbg_data_next;
    logic              dbg_valid_reg, dbg_valid_next;
    logic [DATA_W-1:0] dbg_cap;

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BYPASS_EN(BYPASS_EN)
    ) u_port_dbg (
        .rd_addr (dbg_addr_reg),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .bus_w   (bus_w),
        .reg_data(regs[dbg_addr_reg]),
        .data    (dbg_cap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            dbg_addr_reg  <= '0;
            dbg_data_reg  <= '0;
            dbg_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dbg_addr_reg  <= dbg_addr_next;
            dbg_data_reg  <= dbg_data_next;
            dbg_valid_reg <= dbg_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dbg_addr_next  = dbg_addr_reg;
        dbg_data_next  = dbg_data_reg;
        dbg_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dbg_req) begin
                    dbg_addr_next = dbg_addr;
                    state_next    = CAPTURE;
                end
            end
            CAPTURE: begin
                // Requests arriving here are dropped, not queued.
                dbg_data_next  = dbg_cap;
                dbg_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dbg_data  = dbg_data_reg;
    assign dbg_valid = dbg_valid_reg;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed testbench for reg_bank_wb. Two instances share all inputs: one
// with the bypass enabled and one without, so both read behaviours are
// checked against hand-computed values.
module tb_reg_bank_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] bus_w;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        dbg_req;
    logic [4:0]  dbg_addr;

    logic [31:0] bus_a, bus_b, dbg_data;
    logic        dbg_valid;
    logic [15:0] wr_count;

    logic [31:0] nb_bus_a, nb_bus_b, nb_dbg_data;
    logic        nb_dbg_valid;
    logic [15:0] nb_wr_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_bank_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .bus_w(bus_w),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .bus_a(bus_a), .bus_b(bus_b),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_valid(dbg_valid), .wr_count(wr_count)
    );

    reg_bank_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .bus_w(bus_w),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .bus_a(nb_bus_a), .bus_b(nb_bus_b),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data),
        .dbg_valid(nb_dbg_valid), .wr_count(nb_wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        bus_w   = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; bus_w = '0;
        rd_addr_a = '0; rd_addr_b = '0; dbg_req = 1'b0; dbg_addr = '0;
        #12;
        rst = 1'b0;
        tick();

        // Reset state.
        check("reset_wr_count", 32'(wr_count), 32'd0);
        check("reset_dbg_valid", 32'(dbg_valid), 32'd0);
        check("reset_dbg_data", dbg_data, 32'd0);

        // Write R5, then asynchronous reset clears it without a clock edge.
        write_reg(5'd5, 32'hDEADBEEF);
        rd_addr_a = 5'd5;
        #1;
        check("r5_written", bus_a, 32'hDEADBEEF);
        check("count_after_r5", 32'(wr_count), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_bus_a", bus_a, 32'd0);
        check("async_rst_wr_count", 32'(wr_count), 32'd0);
        check("async_rst_dbg_valid", 32'(dbg_valid), 32'd0);
        rst = 1'b0;
        tick();

        // R0 protection.
        write_reg(5'd0, 32'hFFFFFFFF);
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        #1;
        check("r0_bus_a", bus_a, 32'd0);
        check("r0_bus_b_nb", nb_bus_b, 32'd0);
        check("r0_wr_count", 32'(wr_count), 32'd0);

        // Bypass vs. no bypass.
        write_reg(5'd7, 32'h11111111);
        wr_en = 1'b1; wr_addr = 5'd7; bus_w = 32'h22222222;
        rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
        check("bypass_bus_a", bus_a, 32'h22222222);
        check("bypass_bus_b", bus_b, 32'h22222222);
        check("nobypass_bus_a", nb_bus_a, 32'h11111111);
        check("nobypass_bus_b", nb_bus_b, 32'h11111111);
        tick();
        wr_en = 1'b0;
        #1;
        check("nobypass_after_edge", nb_bus_a, 32'h22222222);
        check("count_after_bypass", 32'(wr_count), 32'd2);

        // Full sweep after a fresh reset.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        check("sweep_wr_count", 32'(wr_count), 32'd31);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check($sformatf("sweep_a_r%0d", i), bus_a, 32'(i) * 32'h01010101);
            check($sformatf("sweep_b_r%0d", 31 - i), bus_b, 32'(31 - i) * 32'h01010101);
        end

        // Debug read timing.
        write_reg(5'd12, 32'hCAFE0012);
        dbg_req = 1'b1; dbg_addr = 5'd12;
        tick();
        dbg_req = 1'b0;
        check("dbg_valid_capture_cycle", 32'(dbg_valid), 32'd0);
        tick();
        check("dbg_valid_pulse", 32'(dbg_valid), 32'd1);
        check("dbg_data_r12", dbg_data, 32'hCAFE0012);
        tick();
        check("dbg_valid_drop", 32'(dbg_valid), 32'd0);

        // Back-to-back request: the second one is ignored.
        dbg_req = 1'b1; dbg_addr = 5'd5;
        tick();
        tick();
        dbg_req = 1'b0;
        check("b2b_valid", 32'(dbg_valid), 32'd1);
        check("b2b_data", dbg_data, 32'h05050505);
        tick();
        check("b2b_second_ignored", 32'(dbg_valid), 32'd0);
        tick();
        check("b2b_still_idle", 32'(dbg_valid), 32'd0);

        // Capture colliding with a write to the same register.
        dbg_req = 1'b1; dbg_addr = 5'd3;
        tick();
        dbg_req = 1'b0;
        write_reg(5'd3, 32'h0000ABCD);
        check("collide_valid", 32'(dbg_valid), 32'd1);
        check("collide_data", dbg_data, 32'h0000ABCD);
        check("collide_data_nb", nb_dbg_data, 32'h03030303);

        // Reset during CAPTURE aborts the read.
        tick();
        dbg_req = 1'b1; dbg_addr = 5'd12;
        tick();
        dbg_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_dbg_valid", 32'(dbg_valid), 32'd0);
        check("abort_dbg_data", dbg_data, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("abort_no_pulse_1", 32'(dbg_valid), 32'd0);
        tick();
        check("abort_no_pulse_2", 32'(dbg_valid), 32'd0);
        check("abort_wr_count", 32'(wr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- Register file that consumes the write-back stage output (`bus_w`) and feeds the decode stage's two operand read ports.
- 32 x 32-bit registers, R0 hardwired to zero.
- Same-cycle write-through bypass so ID reads see the value WB is writing, removing the WB->ID hazard.
- Registered debug read port so the debug unit can dump the register bank while the pipeline runs.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- BYPASS_EN, 1, 1 = write-through bypass on read ports; 0 = reads return the pre-write contents.

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  RegWrite from WB control.
- wr_addr  input  ADDR_W  destination register.
- bus_w  input  DATA_W  write-back data.
- rd_addr_a  input  ADDR_W  rs address.
- rd_addr_b  input  ADDR_W  rt address.
- bus_a  output  DATA_W  rs operand, combinational.
- bus_b  output  DATA_W  rt operand, combinational.
- dbg_req  input  1  debug read request, single-cycle pulse.
- dbg_addr  input  ADDR_W  debug register address.
- dbg_data  output  DATA_W  registered debug read data.
- dbg_valid  output  1  one-cycle strobe, dbg_data is valid.
- wr_count  output  16  saturating count of committed writes to R1..R31.

Behaviour:
- Reset:
  - Asynchronous assertion clears all registers, dbg_data, dbg_valid and wr_count to 0 immediately.
  - Deassertion is taken synchronously at the next clk edge.
- Write:
  - On rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] <= bus_w; wr_count increments, saturating at 16'hFFFF.
  - wr_en=1 with wr_addr=0 is discarded: no state change, no count.
- Read ports (combinational):
  - bus_a = 0 if rd_addr_a==0.
  - Else, if BYPASS_EN and wr_en and wr_addr==rd_addr_a, bus_a = bus_w (write-through).
  - Else bus_a = reg[rd_addr_a].
  - bus_b follows the same rule with rd_addr_b.
  - Both ports may address the same register; both get identical values.
- Debug port:
  - FSM states: IDLE, CAPTURE.
  - IDLE: dbg_req=1 -> latch dbg_addr, go to CAPTURE.
  - CAPTURE: dbg_data <= value at the latched address, applying the same R0 and bypass rules as the read ports in that cycle; dbg_valid=1 for exactly this one cycle; return to IDLE.
  - Latency: request cycle N -> dbg_valid at cycle N+1 (registered output visible after the N+1 edge).
  - dbg_req asserted during CAPTURE is ignored; no queueing.
  - dbg_valid is 0 in IDLE.
- Simultaneous events:
  - A write and a debug capture of the same register in the same cycle -> debug returns the new value (bus_w).
- Reset mid-operation:
  - Reset during CAPTURE aborts the capture; dbg_valid is forced to 0 and the FSM returns to IDLE.
- X-safety:
  - wr_en must never be X after reset; an X on wr_addr while wr_en=0 must not corrupt state.

Decomposition:
- Shared package `dlx_pkg`:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant (5'd0).
  - Debug FSM state encoding: IDLE=1'b0, CAPTURE=1'b1.
- One natural sub-module: `reg_read_port`.
  - Combinational address compare, R0 masking and bypass mux.
  - Instantiated three times: port A, port B, and the debug capture source.

Test Plan:
- Reset:
  - Write 32'hDEADBEEF to R5, assert rst mid-cycle -> bus_a with rd_addr_a=5 reads 0 immediately, with no clk edge needed.
  - wr_count=0 and dbg_valid=0.
- R0 protection:
  - wr_en=1, wr_addr=0, bus_w=32'hFFFFFFFF, then rd_addr_a=0 -> bus_a=0; wr_count unchanged.
- Bypass:
  - R7 holds 32'h11111111.
  - Same cycle as wr_en=1, wr_addr=7, bus_w=32'h22222222, with rd_addr_a=7, rd_addr_b=7 -> bus_a=bus_b=32'h22222222 before the edge.
  - With BYPASS_EN=0 -> 32'h11111111.
- Full sweep:
  - Write reg[i]=i*32'h01010101 for i=1..31, read back on both ports -> all match; R0=0; wr_count=31.
- Debug timing:
  - dbg_req pulse with dbg_addr=12 (R12=32'hCAFE0012) -> dbg_valid high for exactly one cycle, one cycle later, with dbg_data=32'hCAFE0012.
  - Back-to-back dbg_req -> the second request is ignored.
- Debug/write collision and reset abort:
  - Capture of R3 in the same cycle as a write of 32'hABCD to R3 -> dbg_data=32'hABCD.
  - Assert rst while in CAPTURE -> no dbg_valid pulse.
